cpu_ctrl_sequencer: RTL and testbench
=====================================

Name: cpu_ctrl_sequencer

Overview:
- Multi-cycle control unit for the accumulator CPU datapath.
- Issues, cycle by cycle, the 1-bit datapath strobes that are otherwise driven by hand: ACC/PC/stage-register loads, RAM enables, mux selects.
- Decodes opcode and address mode from the stage register and loops fetch/decode/execute until HLT.
- Sits beside the CPU datapath; its outputs connect one-to-one to the datapath control inputs of the same names.

Parameters:
MEM_WAIT, 0, extra wait cycles inserted after every data-RAM read (0..7).
OPW, 5, opcode width; must match StageRegInstr_out.
MODEW, 3, address-mode width; must match StageRegAddrMode_out.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
run  in  1  level; 1 = leave IDLE and start fetching
StageRegInstr_out  in  OPW  current opcode
StageRegAddrMode_out  in  MODEW  0=immediate, 1=direct, 2=indirect; other values are illegal
acc_zero  in  1  accumulator == 0
ACCld_str, ACCinMUXselect, shiftercontrol, ALUinMUXselect, ALUcontrol_in  out  1 each  ACC/ALU controls
DataRAMenable, DataRAMread_en, DRAMaddrMUXselect, IndirectAddrRegld_str  out  1 each  data-RAM controls
InstrRAMenable, InstrRAMread_en, StageRegld_str, StageRegclr  out  1 each  fetch controls
PCounterInccontrol_in, PCounterControl, PCounterclr  out  1 each  PC increment / load (1=jump) / clear
halted  out  1  in HALT state
illegal_op  out  1  sticky; unknown opcode or address mode seen

Behaviour:
- All outputs registered. While reset=0: every output is 0, state = IDLE.
- Strobes are 1-cycle pulses unless stated otherwise.
- States and transitions:
  - IDLE: PCounterclr=1, StageRegclr=1. Goes to FETCH when run=1.
  - FETCH: InstrRAMenable=1, InstrRAMread_en=1. Goes to LOAD.
  - LOAD: StageRegld_str=1. Goes to DECODE.
  - DECODE: no strobes. Goes to INDIR if mode=2; to MEMRD if mode=1 and the opcode uses an operand; otherwise to EXEC.
  - INDIR: DataRAMenable=1, DataRAMread_en=1, DRAMaddrMUXselect=0, IndirectAddrRegld_str=1. Goes to MEMRD.
  - MEMRD: DataRAMenable=1, DataRAMread_en=1, DRAMaddrMUXselect=(mode==2). Held for 1+MEM_WAIT cycles, counted by a 3-bit down-counter. Goes to EXEC.
  - EXEC: opcode-dependent strobes (table below), plus either PCounterInccontrol_in=1 or, on a taken jump, PCounterControl=1. Goes to FETCH; goes to HALT on HLT.
  - HALT: halted=1, no other strobes. Leaves only via reset.
- Opcodes and EXEC strobes:
  - 00 NOP: none.
  - 01 LDA: ACCld_str=1, ACCinMUXselect=0, ALUinMUXselect=mode!=0, pass-through.
  - 02 STA: DataRAMenable=1, DataRAMread_en=0, DRAMaddrMUXselect=(mode==2).
  - 03 ADD: ACCld_str=1, ALUcontrol_in=0.
  - 04 SUB: ACCld_str=1, ALUcontrol_in=1.
  - 05 SHL: ACCld_str=1, shiftercontrol=0.
  - 06 SHR: ACCld_str=1, shiftercontrol=1.
  - 07 IN: ACCld_str=1, ACCinMUXselect=1.
  - 08 OUT: none; the datapath drives CPUoutput from ACC.
  - 09 JMP: PCounterControl=1.
  - 0A JZ: PCounterControl=acc_zero; PCounterInccontrol_in=!acc_zero.
  - 1F HLT: goes to HALT, no PC increment.
- Operand use: only LDA, ADD and SUB read an operand. STA never visits MEMRD. JMP/JZ ignore the mode field and use stage data directly.
- Illegal opcode, or mode >2 on an operand opcode: executed as NOP, PC incremented, illegal_op set. illegal_op is cleared only by reset.
- PCounterInccontrol_in and PCounterControl are never 1 in the same cycle.
- Cycles per instruction (no single-step): immediate 4; direct 5+MEM_WAIT; indirect 6+MEM_WAIT.
- run dropping to 0 mid-instruction has no effect until the next FETCH decision, which returns to IDLE. PC is not cleared by this; PCounterclr pulses only on IDLE entry from reset.
- reset asserted mid-instruction: outputs go to 0 immediately (asynchronous), state returns to IDLE.

Optional Feature:
CTRL_SINGLE_STEP_EN
- Defined: adds input step (1 bit) and state PAUSE. EXEC goes to PAUSE instead of FETCH. PAUSE drives no strobes and advances to FETCH on a 0->1 edge of step, detected with a registered copy. HALT still takes priority.
- Undefined: no step port, no PAUSE state; timing is exactly as above.

Test Plan:
- reset=0 for 3 cycles, then 1 with run=0 -> all strobes 0 except PCounterclr=1 and StageRegclr=1 on IDLE entry; halted=0.
- run=1, opcode 03, mode 0 -> strobes in order FETCH, LOAD, DECODE, EXEC; ACCld_str=1 and ALUcontrol_in=0 only in cycle 4; PCounterInccontrol_in=1 in cycle 4.
- opcode 04, mode 2, MEM_WAIT=2 -> IndirectAddrRegld_str in cycle 4; DataRAMread_en high cycles 5-7 with DRAMaddrMUXselect=1; EXEC in cycle 8 with ALUcontrol_in=1.
- opcode 0A with acc_zero=1, then with acc_zero=0 -> first: PCounterControl=1, PCounterInccontrol_in=0; second: the reverse.
- opcode 11 -> no ACC or RAM strobes, PC incremented, illegal_op=1 and held; then opcode 1F -> halted=1 and stays 1 across 20 cycles.
- reset pulsed low during MEMRD -> all outputs 0 asynchronously; after release, restarts from IDLE.

Source files
------------

// File: rtl/cpu_ctrl_sequencer_if.sv
// Control bus between the multi-cycle sequencer and the accumulator CPU datapath.
//
// Signals
//   Status into the sequencer : run, StageRegInstr_out, StageRegAddrMode_out, acc_zero
//                               (+ step when CTRL_SINGLE_STEP_EN is defined)
//   Strobes to the datapath   : ACC/ALU, data-RAM, fetch and PC controls, plus halted/illegal_op
//
// Modports
//   master : the sequencer (drives strobes, reads status)
//   slave  : the datapath / environment (drives status, reads strobes)
//
// Optional macro: CTRL_SINGLE_STEP_EN adds the step input.
interface cpu_ctrl_sequencer_if #(
    parameter int unsigned OPW   = 5,
    parameter int unsigned MODEW = 3
);
    logic             run;
    logic [OPW-1:0]   StageRegInstr_out;
    logic [MODEW-1:0] StageRegAddrMode_out;
    logic             acc_zero;
`ifdef CTRL_SINGLE_STEP_EN
    logic             step;
`endif

    logic ACCld_str;
    logic ACCinMUXselect;
    logic shiftercontrol;
    logic ALUinMUXselect;
    logic ALUcontrol_in;
    logic DataRAMenable;
    logic DataRAMread_en;
    logic DRAMaddrMUXselect;
    logic IndirectAddrRegld_str;
    logic InstrRAMenable;
    logic InstrRAMread_en;
    logic StageRegld_str;
    logic StageRegclr;
    logic PCounterInccontrol_in;
    logic PCounterControl;
    logic PCounterclr;
    logic halted;
    logic illegal_op;

    modport master (
`ifdef CTRL_SINGLE_STEP_EN
        input  step,
`endif
        input  run, StageRegInstr_out, StageRegAddrMode_out, acc_zero,
        output ACCld_str, ACCinMUXselect, shiftercontrol, ALUinMUXselect, ALUcontrol_in,
        output DataRAMenable, DataRAMread_en, DRAMaddrMUXselect, IndirectAddrRegld_str,
        output InstrRAMenable, InstrRAMread_en, StageRegld_str, StageRegclr,
        output PCounterInccontrol_in, PCounterControl, PCounterclr, halted, illegal_op
    );

    modport slave (
`ifdef CTRL_SINGLE_STEP_EN
        output step,
`endif
        output run, StageRegInstr_out, StageRegAddrMode_out, acc_zero,
        input  ACCld_str, ACCinMUXselect, shiftercontrol, ALUinMUXselect, ALUcontrol_in,
        input  DataRAMenable, DataRAMread_en, DRAMaddrMUXselect, IndirectAddrRegld_str,
        input  InstrRAMenable, InstrRAMread_en, StageRegld_str, StageRegclr,
        input  PCounterInccontrol_in, PCounterControl, PCounterclr, halted, illegal_op
    );
endinterface

// File: rtl/cpu_ctrl_sequencer.sv
// Multi-cycle control sequencer for the accumulator CPU datapath.
// Loops FETCH -> LOAD -> DECODE -> [INDIR] -> [MEMRD] -> EXEC until HLT, issuing the
// datapath strobes for each cycle. Every output is a register whose value is decided
// from the state being entered, so strobes line up exactly with the state they belong to.
//
// Ports
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset; all outputs 0 and state IDLE while low
//   ctrl  : cpu_ctrl_sequencer_if.master (status in, strobes out)
//
// Parameters
//   MEM_WAIT : extra wait cycles after every data-RAM read (0..7)
//   OPW      : opcode width
//   MODEW    : address-mode width
//
// Optional macro: CTRL_SINGLE_STEP_EN adds a PAUSE state after EXEC, released by a
// rising edge on ctrl.step.
module cpu_ctrl_sequencer #(
    parameter int unsigned MEM_WAIT = 0,
    parameter int unsigned OPW      = 5,
    parameter int unsigned MODEW    = 3
) (
    input logic                  clk,
    input logic                  reset,
    cpu_ctrl_sequencer_if.master ctrl
);

    localparam logic [OPW-1:0] OpNop = OPW'(5'h00);
    localparam logic [OPW-1:0] OpLda = OPW'(5'h01);
    localparam logic [OPW-1:0] OpSta = OPW'(5'h02);
    localparam logic [OPW-1:0] OpAdd = OPW'(5'h03);
    localparam logic [OPW-1:0] OpSub = OPW'(5'h04);
    localparam logic [OPW-1:0] OpShl = OPW'(5'h05);
    localparam logic [OPW-1:0] OpShr = OPW'(5'h06);
    localparam logic [OPW-1:0] OpIn  = OPW'(5'h07);
    localparam logic [OPW-1:0] OpOut = OPW'(5'h08);
    localparam logic [OPW-1:0] OpJmp = OPW'(5'h09);
    localparam logic [OPW-1:0] OpJz  = OPW'(5'h0A);
    localparam logic [OPW-1:0] OpHlt = OPW'(5'h1F);

    localparam logic [MODEW-1:0] ModeImm = MODEW'(0);
    localparam logic [MODEW-1:0] ModeDir = MODEW'(1);
    localparam logic [MODEW-1:0] ModeInd = MODEW'(2);

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StLoad,
        StDecode,
        StIndir,
        StMemRd,
        StExec,
`ifdef CTRL_SINGLE_STEP_EN
        StPause,
`endif
        StHalt
    } state_t;

    typedef struct packed {
        logic ACCld_str;
        logic ACCinMUXselect;
        logic shiftercontrol;
        logic ALUinMUXselect;
        logic ALUcontrol_in;
        logic DataRAMenable;
        logic DataRAMread_en;
        logic DRAMaddrMUXselect;
        logic IndirectAddrRegld_str;
        logic InstrRAMenable;
        logic InstrRAMread_en;
        logic StageRegld_str;
        logic StageRegclr;
        logic PCounterInccontrol_in;
        logic PCounterControl;
        logic PCounterclr;
        logic halted;
        logic illegal_op;
    } strobes_t;

    state_t   state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    // Set by reset so the first clock after release is treated as the IDLE entry that
    // clears the PC; a later return to IDLE (run dropped) leaves the PC alone.
    logic     rstEntry_q;
    strobes_t strb_q, strb_d;

    logic [OPW-1:0]   opc;
    logic [MODEW-1:0] mode;
    logic isOperandOp, isSta, isHlt, isKnownOp, isIllegal;

    assign opc  = ctrl.StageRegInstr_out;
    assign mode = ctrl.StageRegAddrMode_out;

    always_comb begin
        isOperandOp = (opc == OpLda) || (opc == OpAdd) || (opc == OpSub);
        isSta       = (opc == OpSta);
        isHlt       = (opc == OpHlt);
        // 00..0A are contiguous, HLT is the only other legal code.
        isKnownOp   = (opc <= OpJz) || isHlt;
        isIllegal   = !isKnownOp || (isOperandOp && (mode > ModeInd));
    end

`ifdef CTRL_SINGLE_STEP_EN
    logic stepPrev_q;
    logic stepEdge;
    assign stepEdge = ctrl.step & ~stepPrev_q;
`endif

    // Next state and wait counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (!rstEntry_q && ctrl.run) state_d = StFetch;
            end
            StFetch:  state_d = StLoad;
            StLoad:   state_d = StDecode;
            StDecode: begin
                if (isIllegal) begin
                    state_d = StExec;
                end else if (mode == ModeInd && (isOperandOp || isSta)) begin
                    state_d = StIndir;
                end else if (mode == ModeDir && isOperandOp) begin
                    state_d = StMemRd;
                end else begin
                    state_d = StExec;
                end
            end
            // STA only needs the pointer; it writes in EXEC and never reads data.
            StIndir:  state_d = isOperandOp ? StMemRd : StExec;
            StMemRd: begin
                if (cnt_q == 3'd0) state_d = StExec;
                else               cnt_d = cnt_q - 3'd1;
            end
            StExec: begin
                if (isHlt) begin
                    state_d = StHalt;
                end else begin
`ifdef CTRL_SINGLE_STEP_EN
                    state_d = StPause;
`else
                    state_d = ctrl.run ? StFetch : StIdle;
`endif
                end
            end
`ifdef CTRL_SINGLE_STEP_EN
            StPause: begin
                if (stepEdge) state_d = ctrl.run ? StFetch : StIdle;
            end
`endif
            StHalt:  state_d = StHalt;
            default: state_d = StIdle;
        endcase
        if (rstEntry_q) state_d = StIdle;
        if (state_d == StMemRd && state_q != StMemRd) cnt_d = 3'(MEM_WAIT);
    end

    // Strobes for the state being entered; registered below.
    always_comb begin
        strb_d            = '0;
        strb_d.illegal_op = strb_q.illegal_op;
        case (state_d)
            StIdle: begin
                strb_d.StageRegclr = (state_q != StIdle) || rstEntry_q;
                strb_d.PCounterclr = rstEntry_q;
            end
            StFetch: begin
                strb_d.InstrRAMenable  = 1'b1;
                strb_d.InstrRAMread_en = 1'b1;
            end
            StLoad: strb_d.StageRegld_str = 1'b1;
            StIndir: begin
                strb_d.DataRAMenable         = 1'b1;
                strb_d.DataRAMread_en        = 1'b1;
                strb_d.IndirectAddrRegld_str = 1'b1;
            end
            StMemRd: begin
                strb_d.DataRAMenable     = 1'b1;
                strb_d.DataRAMread_en    = 1'b1;
                strb_d.DRAMaddrMUXselect = (mode == ModeInd);
            end
            StExec: begin
                if (isIllegal) begin
                    strb_d.PCounterInccontrol_in = 1'b1;
                    strb_d.illegal_op            = 1'b1;
                end else begin
                    strb_d.PCounterInccontrol_in = 1'b1;
                    case (opc)
                        OpLda: begin
                            strb_d.ACCld_str      = 1'b1;
                            strb_d.ALUinMUXselect = (mode != ModeImm);
                        end
                        OpSta: begin
                            strb_d.DataRAMenable     = 1'b1;
                            strb_d.DRAMaddrMUXselect = (mode == ModeInd);
                        end
                        OpAdd: strb_d.ACCld_str = 1'b1;
                        OpSub: begin
                            strb_d.ACCld_str     = 1'b1;
                            strb_d.ALUcontrol_in = 1'b1;
                        end
                        OpShl: strb_d.ACCld_str = 1'b1;
                        OpShr: begin
                            strb_d.ACCld_str      = 1'b1;
                            strb_d.shiftercontrol = 1'b1;
                        end
                        OpIn: begin
                            strb_d.ACCld_str      = 1'b1;
                            strb_d.ACCinMUXselect = 1'b1;
                        end
                        OpJmp: begin
                            strb_d.PCounterInccontrol_in = 1'b0;
                            strb_d.PCounterControl       = 1'b1;
                        end
                        OpJz: begin
                            strb_d.PCounterInccontrol_in = ~ctrl.acc_zero;
                            strb_d.PCounterControl       = ctrl.acc_zero;
                        end
                        OpHlt: strb_d.PCounterInccontrol_in = 1'b0;
                        OpNop, OpOut: ;
                        default: ;
                    endcase
                end
            end
            StHalt:  strb_d.halted = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= 3'd0;
            rstEntry_q <= 1'b1;
            strb_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rstEntry_q <= 1'b0;
            strb_q     <= strb_d;
        end
    end

`ifdef CTRL_SINGLE_STEP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stepPrev_q <= 1'b0;
        else        stepPrev_q <= ctrl.step;
    end
`endif

    assign ctrl.ACCld_str             = strb_q.ACCld_str;
    assign ctrl.ACCinMUXselect        = strb_q.ACCinMUXselect;
    assign ctrl.shiftercontrol        = strb_q.shiftercontrol;
    assign ctrl.ALUinMUXselect        = strb_q.ALUinMUXselect;
    assign ctrl.ALUcontrol_in         = strb_q.ALUcontrol_in;
    assign ctrl.DataRAMenable         = strb_q.DataRAMenable;
    assign ctrl.DataRAMread_en        = strb_q.DataRAMread_en;
    assign ctrl.DRAMaddrMUXselect     = strb_q.DRAMaddrMUXselect;
    assign ctrl.IndirectAddrRegld_str = strb_q.IndirectAddrRegld_str;
    assign ctrl.InstrRAMenable        = strb_q.InstrRAMenable;
    assign ctrl.InstrRAMread_en       = strb_q.InstrRAMread_en;
    assign ctrl.StageRegld_str        = strb_q.StageRegld_str;
    assign ctrl.StageRegclr           = strb_q.StageRegclr;
    assign ctrl.PCounterInccontrol_in = strb_q.PCounterInccontrol_in;
    assign ctrl.PCounterControl       = strb_q.PCounterControl;
    assign ctrl.PCounterclr           = strb_q.PCounterclr;
    assign ctrl.halted                = strb_q.halted;
    assign ctrl.illegal_op            = strb_q.illegal_op;

endmodule

// File: tb/tb_cpu_ctrl_sequencer.sv
// Directed bench for cpu_ctrl_sequencer. Expected strobe vectors are queued when an
// instruction is driven and popped one per clock, sampled 1 time unit after the edge.
module tb_cpu_ctrl_sequencer;

    localparam int MW = 2;

    typedef struct packed {
        logic ACCld_str;
        logic ACCinMUXselect;
        logic shiftercontrol;
        logic ALUinMUXselect;
        logic ALUcontrol_in;
        logic DataRAMenable;
        logic DataRAMread_en;
        logic DRAMaddrMUXselect;
        logic IndirectAddrRegld_str;
        logic InstrRAMenable;
        logic InstrRAMread_en;
        logic StageRegld_str;
        logic StageRegclr;
        logic PCounterInccontrol_in;
        logic PCounterControl;
        logic PCounterclr;
        logic halted;
        logic illegal_op;
    } strb_t;

    logic clk = 1'b0;
    logic reset;

    cpu_ctrl_sequencer_if #(.OPW(5), .MODEW(3)) bus ();

    cpu_ctrl_sequencer #(.MEM_WAIT(MW), .OPW(5), .MODEW(3)) dut (
        .clk  (clk),
        .reset(reset),
        .ctrl (bus)
    );

    always #5 clk = ~clk;

    strb_t expQ[$];
    string tagQ[$];
    int    nCompared = 0;
    int    nMismatch = 0;
    bit    illSticky = 1'b0;

    function automatic strb_t obs();
        strb_t s;
        s.ACCld_str             = bus.ACCld_str;
        s.ACCinMUXselect        = bus.ACCinMUXselect;
        s.shiftercontrol        = bus.shiftercontrol;
        s.ALUinMUXselect        = bus.ALUinMUXselect;
        s.ALUcontrol_in         = bus.ALUcontrol_in;
        s.DataRAMenable         = bus.DataRAMenable;
        s.DataRAMread_en        = bus.DataRAMread_en;
        s.DRAMaddrMUXselect     = bus.DRAMaddrMUXselect;
        s.IndirectAddrRegld_str = bus.IndirectAddrRegld_str;
        s.InstrRAMenable        = bus.InstrRAMenable;
        s.InstrRAMread_en       = bus.InstrRAMread_en;
        s.StageRegld_str        = bus.StageRegld_str;
        s.StageRegclr           = bus.StageRegclr;
        s.PCounterInccontrol_in = bus.PCounterInccontrol_in;
        s.PCounterControl       = bus.PCounterControl;
        s.PCounterclr           = bus.PCounterclr;
        s.halted                = bus.halted;
        s.illegal_op            = bus.illegal_op;
        return s;
    endfunction

    task automatic push(input strb_t s, input string t);
        s.illegal_op = s.illegal_op | illSticky;
        expQ.push_back(s);
        tagQ.push_back(t);
    endtask

    task automatic checkOne();
        strb_t e;
        strb_t o;
        string t;
        e = expQ.pop_front();
        t = tagQ.pop_front();
        o = obs();
        nCompared++;
        assert (o === e) else begin
            nMismatch++;
            $error("FAIL %s: observed %b expected %b", t, o, e);
        end
    endtask

    task automatic drain();
        while (expQ.size() > 0) begin
            @(posedge clk);
            #1;
            checkOne();
        end
    endtask

    // Asynchronous reset: outputs must drop before any clock edge.
    task automatic doReset();
        strb_t z;
        strb_t c;
        z = '0;
        reset = 1'b0;
        illSticky = 1'b0;
        #1;
        push(z, "rst.async");
        checkOne();
        for (int i = 0; i < 3; i++) push(z, "rst.held");
        drain();
        reset = 1'b1;
        c = '0;
        c.PCounterclr = 1'b1;
        c.StageRegclr = 1'b1;
        push(c, "rst.idleEntry");
        drain();
    endtask

    // path: 0 immediate, 1 direct, 2 indirect (operand opcodes)
    task automatic runInstr(input logic [4:0] op, input logic [2:0] md, input logic az,
                            input int path, input bit dropRun, input strb_t ex,
                            input string tag);
        strb_t s;
        bus.run = 1'b1;
        s = '0; s.InstrRAMenable = 1'b1; s.InstrRAMread_en = 1'b1;
        push(s, {tag, ".fetch"});
        s = '0; s.StageRegld_str = 1'b1;
        push(s, {tag, ".load"});
        s = '0;
        push(s, {tag, ".decode"});
        if (path == 2) begin
            s = '0; s.DataRAMenable = 1'b1; s.DataRAMread_en = 1'b1;
            s.IndirectAddrRegld_str = 1'b1;
            push(s, {tag, ".indir"});
        end
        if (path >= 1) begin
            for (int i = 0; i <= MW; i++) begin
                s = '0; s.DataRAMenable = 1'b1; s.DataRAMread_en = 1'b1;
                s.DRAMaddrMUXselect = (path == 2);
                push(s, {tag, ".memrd"});
            end
        end
        push(ex, {tag, ".exec"});
        @(posedge clk);
        #1;
        checkOne();
        // Stage register contents change only after FETCH.
        bus.StageRegInstr_out = op;
        bus.StageRegAddrMode_out = md;
        bus.acc_zero = az;
        if (dropRun) bus.run = 1'b0;
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        strb_t ex;
        strb_t z;
        z = '0;
        reset = 1'b1;
        bus.run = 1'b0;
        bus.StageRegInstr_out = 5'h00;
        bus.StageRegAddrMode_out = 3'd0;
        bus.acc_zero = 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
        bus.step = 1'b0;
`endif
        #2;
        doReset();
        push(z, "idle.run0");
        drain();

        ex = '0; ex.ACCld_str = 1'b1; ex.PCounterInccontrol_in = 1'b1;
        runInstr(5'h03, 3'd0, 1'b0, 0, 1'b0, ex, "add.imm");

        ex = '0; ex.ACCld_str = 1'b1; ex.ALUcontrol_in = 1'b1; ex.PCounterInccontrol_in = 1'b1;
        runInstr(5'h04, 3'd2, 1'b0, 2, 1'b0, ex, "sub.ind");

        ex = '0; ex.ACCld_str = 1'b1; ex.ALUinMUXselect = 1'b1; ex.PCounterInccontrol_in = 1'b1;
        runInstr(5'h01, 3'd1, 1'b0, 1, 1'b0, ex, "lda.dir");

        ex = '0; ex.PCounterControl = 1'b1;
        runInstr(5'h0A, 3'd0, 1'b1, 0, 1'b0, ex, "jz.taken");

        ex = '0; ex.PCounterInccontrol_in = 1'b1;
        runInstr(5'h0A, 3'd0, 1'b0, 0, 1'b0, ex, "jz.nottaken");

        ex = '0; ex.DataRAMenable = 1'b1; ex.PCounterInccontrol_in = 1'b1;
        runInstr(5'h02, 3'd1, 1'b0, 0, 1'b0, ex, "sta.dir");

        ex = '0; ex.ACCld_str = 1'b1; ex.shiftercontrol = 1'b1; ex.PCounterInccontrol_in = 1'b1;
        runInstr(5'h06, 3'd0, 1'b0, 0, 1'b0, ex, "shr");

        ex = '0; ex.ACCld_str = 1'b1; ex.ACCinMUXselect = 1'b1; ex.PCounterInccontrol_in = 1'b1;
        runInstr(5'h07, 3'd0, 1'b0, 0, 1'b0, ex, "in");

        // run dropped mid-instruction: finishes, then IDLE without clearing the PC.
        ex = '0; ex.ACCld_str = 1'b1; ex.PCounterInccontrol_in = 1'b1;
        runInstr(5'h03, 3'd0, 1'b0, 0, 1'b1, ex, "add.rundrop");
        ex = '0; ex.StageRegclr = 1'b1;
        push(ex, "idle.reentry");
        push(z, "idle.stay");
        drain();

        ex = '0; ex.PCounterControl = 1'b1;
        runInstr(5'h09, 3'd2, 1'b0, 0, 1'b0, ex, "jmp");

        ex = '0; ex.PCounterInccontrol_in = 1'b1; ex.illegal_op = 1'b1;
        runInstr(5'h11, 3'd0, 1'b0, 0, 1'b0, ex, "illegal.op");
        illSticky = 1'b1;

        ex = '0; ex.PCounterInccontrol_in = 1'b1;
        runInstr(5'h03, 3'd3, 1'b0, 0, 1'b0, ex, "illegal.mode");

        ex = '0;
        runInstr(5'h1F, 3'd0, 1'b0, 0, 1'b0, ex, "hlt");
        ex = '0; ex.halted = 1'b1;
        for (int i = 0; i < 20; i++) push(ex, "halt.hold");
        drain();

        // Leave HALT by reset, then interrupt a direct LDA during MEMRD.
        doReset();
        bus.StageRegInstr_out = 5'h01;
        bus.StageRegAddrMode_out = 3'd1;
        ex = '0; ex.InstrRAMenable = 1'b1; ex.InstrRAMread_en = 1'b1;
        push(ex, "mid.fetch");
        ex = '0; ex.StageRegld_str = 1'b1;
        push(ex, "mid.load");
        push(z, "mid.decode");
        ex = '0; ex.DataRAMenable = 1'b1; ex.DataRAMread_en = 1'b1;
        push(ex, "mid.memrd");
        drain();
        doReset();

        ex = '0; ex.ACCld_str = 1'b1; ex.PCounterInccontrol_in = 1'b1;
        runInstr(5'h03, 3'd0, 1'b0, 0, 1'b0, ex, "add.restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
